// File: rtl/z80_mem_pkg.sv
// Shared definitions for the Z80 / host BSRAM arbiter: default widths,
// ROM boundary and the arbiter FSM state encoding.
package z80_mem_pkg;

    localparam int          DEF_ADDR_W  = 16;
    localparam int          DEF_DATA_W  = 8;
    localparam logic [15:0] DEF_ROM_TOP = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ZRD  = 2'd1,
        ST_HRD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/z80_mem_arbiter_edge_pending.sv
// Rising-edge detector with a one-deep pending flag. A new edge merges into
// an already pending request; clr retires the request being served.
module edge_pending (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic inhibit,
    input  logic clr,
    output logic rise,
    output logic req
);

    logic level_q, level_d;
    logic pend_q, pend_d;

    always_comb begin
        level_d = level;
        rise    = level & ~level_q;
        // The request is visible in the same cycle as its edge so the
        // arbiter can issue without first waiting for the flag to register.
        req     = pend_q | (rise & ~inhibit);
        pend_d  = req & ~clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= level;
            pend_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/z80_mem_arbiter.sv
// Single-port BSRAM arbiter: Z80 bus accesses take absolute priority, a host
// loader port fills idle cycles, and Z80 writes into ROM are suppressed.
module z80_mem_arbiter
    import z80_mem_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] ROM_TOP     = ADDR_W'(DEF_ROM_TOP),
    parameter bit                HOST_ROM_WR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic              z80_rd,
    input  logic              z80_wr,
    input  logic [DATA_W-1:0] z80_wdata,
    output logic [DATA_W-1:0] z80_rdata,
    output logic              z80_rvalid,
    output logic              z80_wr_blocked,
    output logic              z80_err,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_e state_q, state_d;

    logic rd_rise, rd_req, rd_clr;
    logic wr_rise, wr_req, wr_clr;
    logic z80_in_rom, host_wr_blocked;
    logic host_ready_int;

    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              zcap_q, zcap_d;
    logic              hcap_q, hcap_d;
    logic [DATA_W-1:0] z80_rdata_q, z80_rdata_d;
    logic              z80_rvalid_q, z80_rvalid_d;
    logic              z80_wr_blocked_q, z80_wr_blocked_d;
    logic              z80_err_q, z80_err_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;

    edge_pending u_rd_pend (
        .clk     (clk),
        .reset   (reset),
        .level   (z80_rd),
        .inhibit (1'b0),
        .clr     (rd_clr),
        .rise    (rd_rise),
        .req     (rd_req)
    );

    // A write edge coinciding with a read edge is dropped; the read wins.
    edge_pending u_wr_pend (
        .clk     (clk),
        .reset   (reset),
        .level   (z80_wr),
        .inhibit (rd_rise),
        .clr     (wr_clr),
        .rise    (wr_rise),
        .req     (wr_req)
    );

    assign z80_in_rom      = (z80_addr < ROM_TOP);
    assign host_wr_blocked = !HOST_ROM_WR && (host_addr < ROM_TOP);

    always_comb begin
        state_d          = state_q;
        ram_en_d         = 1'b0;
        ram_we_d         = 1'b0;
        ram_addr_d       = ram_addr_q;
        ram_wdata_d      = ram_wdata_q;
        zcap_d           = 1'b0;
        hcap_d           = 1'b0;
        rd_clr           = 1'b0;
        wr_clr           = 1'b0;
        z80_wr_blocked_d = 1'b0;
        host_ready_int   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = z80_addr;
                    rd_clr     = 1'b1;
                    state_d    = ST_ZRD;
                end else if (wr_req) begin
                    wr_clr = 1'b1;
                    if (z80_in_rom) begin
                        z80_wr_blocked_d = 1'b1;
                    end else begin
                        ram_en_d    = 1'b1;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = z80_addr;
                        ram_wdata_d = z80_wdata;
                    end
                end else begin
                    host_ready_int = 1'b1;
                    if (host_valid) begin
                        if (host_we) begin
                            // Blocked host writes are acknowledged but never reach the RAM.
                            if (!host_wr_blocked) begin
                                ram_en_d    = 1'b1;
                                ram_we_d    = 1'b1;
                                ram_addr_d  = host_addr;
                                ram_wdata_d = host_wdata;
                            end
                        end else begin
                            ram_en_d   = 1'b1;
                            ram_addr_d = host_addr;
                            state_d    = ST_HRD;
                        end
                    end
                end
            end
            // Read data appears the cycle after ZRD/HRD; the capture flag
            // lets IDLE issue the next access while the data is taken.
            ST_ZRD: begin
                zcap_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_HRD: begin
                hcap_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        z80_rdata_d   = zcap_q ? ram_rdata : z80_rdata_q;
        z80_rvalid_d  = zcap_q;
        host_rdata_d  = hcap_q ? ram_rdata : host_rdata_q;
        host_rvalid_d = hcap_q;
        z80_err_d     = rd_rise & wr_rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            ram_en_q         <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_addr_q       <= '0;
            ram_wdata_q      <= '0;
            zcap_q           <= 1'b0;
            hcap_q           <= 1'b0;
            z80_rdata_q      <= '0;
            z80_rvalid_q     <= 1'b0;
            z80_wr_blocked_q <= 1'b0;
            z80_err_q        <= 1'b0;
            host_rdata_q     <= '0;
            host_rvalid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            ram_en_q         <= ram_en_d;
            ram_we_q         <= ram_we_d;
            ram_addr_q       <= ram_addr_d;
            ram_wdata_q      <= ram_wdata_d;
            zcap_q           <= zcap_d;
            hcap_q           <= hcap_d;
            z80_rdata_q      <= z80_rdata_d;
            z80_rvalid_q     <= z80_rvalid_d;
            z80_wr_blocked_q <= z80_wr_blocked_d;
            z80_err_q        <= z80_err_d;
            host_rdata_q     <= host_rdata_d;
            host_rvalid_q    <= host_rvalid_d;
        end
    end

    assign host_ready     = host_ready_int & ~reset;
    assign ram_en         = ram_en_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign z80_rdata      = z80_rdata_q;
    assign z80_rvalid     = z80_rvalid_q;
    assign z80_wr_blocked = z80_wr_blocked_q;
    assign z80_err        = z80_err_q;
    assign host_rdata     = host_rdata_q;
    assign host_rvalid    = host_rvalid_q;

endmodule

// File: doc/z80_mem_arbiter.md
Name: z80_mem_arbiter

Overview:
- Shares the single-port synchronous BSRAM that backs the Z80 address space between two requesters: the Z80 bus (already-synchronised strobes) and a host loader/debug port driven by a UART monitor.
- Z80 accesses have absolute priority. Host accesses use idle RAM cycles.
- Enforces write protection of the ROM region for Z80 writes only, so the host can preload ROM images.
- Sits between the Z80 bus-decode logic and the memory array in the top level.

Parameters:
- ADDR_W, 16, address width of RAM and both requesters.
- DATA_W, 8, data width.
- ROM_TOP, 16'h8000, addresses below this are ROM; Z80 writes there are blocked.
- HOST_ROM_WR, 1, when 1 the host may write below ROM_TOP; when 0, host writes there are also blocked.

Ports:
- clk  in  1  system clock (27 MHz).
- reset  in  1  synchronous, active-high reset.
- z80_addr  in  ADDR_W  Z80 address, latched by bus logic and stable while a strobe is high.
- z80_rd  in  1  synchronised level, high = Z80 memory read (MREQ & RD).
- z80_wr  in  1  synchronised level, high = Z80 memory write (MREQ & WR).
- z80_wdata  in  DATA_W  Z80 write data.
- z80_rdata  out  DATA_W  last Z80 read result, held until the next read.
- z80_rvalid  out  1  one-cycle pulse when z80_rdata updates.
- z80_wr_blocked  out  1  one-cycle pulse when a Z80 write hits ROM.
- z80_err  out  1  one-cycle pulse when rd and wr rising edges coincide.
- host_valid  in  1  host request.
- host_ready  out  1  host request accepted this cycle.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read result.
- host_rvalid  out  1  one-cycle pulse when host_rdata is valid.
- ram_en  out  1  RAM access enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Reset:
  - All outputs 0; FSM to IDLE; pending flags cleared.
  - Edge-history registers load the current z80_rd/z80_wr values during reset, so a level already high at reset release produces no edge.
- Z80 request detection:
  - A rising edge of z80_rd or z80_wr sets the corresponding pending flag (one deep).
  - A repeated edge while the flag is still pending is merged into it.
  - If rd and wr edges arrive in the same cycle, rd is taken, wr is dropped, and z80_err pulses.
- FSM states: IDLE, ZRD, HRD.
  - Priority is evaluated in IDLE each cycle: pending Z80 read > pending Z80 write > host.
- Z80 read:
  - IDLE issues ram_en=1, ram_we=0, ram_addr=z80_addr next cycle, then moves to ZRD.
  - ZRD captures ram_rdata into z80_rdata, pulses z80_rvalid, and returns to IDLE.
  - Latency from the edge-sample cycle N: ram_en at N+1, z80_rvalid at N+3.
  - Worst case, when a host read is in flight: z80_rvalid at N+4.
- Z80 write:
  - IDLE issues ram_en=1, ram_we=1 next cycle and stays in IDLE (single cycle).
  - If z80_addr < ROM_TOP, no RAM access is issued and z80_wr_blocked pulses instead.
  - The pending flag is cleared in both cases.
- Host access:
  - host_ready=1 only in IDLE with no Z80 flag pending and no Z80 edge detected this cycle.
  - Acceptance occurs on host_valid & host_ready.
  - Write: a single RAM write the next cycle. If blocked by ROM_TOP/HOST_ROM_WR, the write is dropped silently but still acknowledged.
  - Read: RAM read, then HRD, then host_rdata captured and host_rvalid pulsed; latency 3 cycles from acceptance.
- Host starvation: none guaranteed beyond Z80 idle gaps. The Z80 strobe rate is less than 1/6 of clk, so the host always finds slots.
- Back-to-back: a new access may issue the cycle after a write, or the cycle after ZRD/HRD.
- ram_en and ram_we return to 0 in every cycle that does not issue an access.
- Reset mid-operation: the in-flight read is discarded, no rvalid pulse is produced, and all flags are cleared.
- Address arithmetic: pure compare; ROM_TOP=0 disables protection.

Decomposition:
- Shared package `z80_mem_pkg`:
  - FSM state encoding (IDLE/ZRD/HRD).
  - ADDR_W/DATA_W defaults.
  - ROM_TOP default.
- Sub-module `edge_pending`: edge detector plus one-deep pending flag with clear input, instantiated twice (rd, wr).

Test Plan:
- Z80 read at 0x0100 with RAM holding 0x3E, rd edge at cycle N -> ram_en=1/ram_we=0/ram_addr=0x0100 at N+1; z80_rdata=0x3E with z80_rvalid at N+3.
- Z80 write 0x55 to 0x8001 -> one RAM write cycle at 0x8001. Z80 write 0xAA to 0x0010 -> no ram_en, z80_wr_blocked pulse, RAM unchanged.
- Host write 0xC3 to 0x0000 with HOST_ROM_WR=1 -> accepted, RAM[0]=0xC3. Same test with HOST_ROM_WR=0 -> host_ready pulse, no RAM write.
- Host read in flight (HRD) when a Z80 rd edge arrives -> Z80 read issues the cycle after HRD, z80_rvalid at N+4, host_rvalid unaffected and correct.
- host_valid held continuously while the Z80 strobes every 6 cycles -> host_ready never coincides with a pending Z80 flag; all host and Z80 data are correct across 256 mixed accesses, checked against a scoreboard.
- z80_rd high during reset, then released -> no read issued. Reset asserted in ZRD -> no z80_rvalid, outputs 0 the next cycle. Simultaneous rd/wr edge -> read performed, z80_err pulse.
